// File: rtl/e1b_chip_nco.sv
// E1B per-channel code-phase generator: code NCO driving a half/full-chip
// counter that wraps at the primary code length and flags code epochs.
module e1b_chip_nco #(
  parameter int E1B_CODEBITS = 12,
  parameter int E1B_CODELEN  = 4092,
  parameter int NCO_BITS     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    init,
  input  logic                    rate_wr,
  input  logic [NCO_BITS-1:0]     rate,
  input  logic                    slew_wr,
  input  logic [15:0]             slew,
  output logic [E1B_CODEBITS-1:0] nchip,
  output logic                    full_chip,
  output logic                    half_chip,
  output logic                    epoch,
  output logic                    slewing
);

  localparam logic [E1B_CODEBITS-1:0] LAST_CHIP = E1B_CODEBITS'(E1B_CODELEN - 1);
  localparam logic [E1B_CODEBITS-1:0] CHIP_ONE  = E1B_CODEBITS'(1);

  logic [NCO_BITS-1:0] phase;
  logic [NCO_BITS-1:0] rate_q;
  logic [15:0]         slew_cnt;
  logic                half;

  logic [NCO_BITS:0]   nco_sum;
  logic                tick;
  logic [15:0]         slew_eff;
  logic [15:0]         slew_nxt;
  logic                adv;

  // A same-cycle slew_wr is applied first, so a coincident tick is swallowed
  // against the freshly loaded count.
  always_comb begin
    nco_sum  = {1'b0, phase} + {1'b0, rate_q};
    tick     = ena & nco_sum[NCO_BITS];
    slew_eff = slew_wr ? slew : slew_cnt;
    slew_nxt = slew_eff;
    adv      = 1'b0;
    if (tick) begin
      if (slew_eff != '0) begin
        slew_nxt = slew_eff - 16'd1;
      end else begin
        adv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      rate_q    <= '0;
      slew_cnt  <= '0;
      half      <= 1'b0;
      nchip     <= '0;
      full_chip <= 1'b0;
      half_chip <= 1'b0;
      epoch     <= 1'b0;
      slewing   <= 1'b0;
    end else begin
      if (rate_wr) begin
        rate_q <= rate;
      end
      full_chip <= 1'b0;
      half_chip <= 1'b0;
      epoch     <= 1'b0;
      if (init) begin
        phase    <= '0;
        half     <= 1'b0;
        nchip    <= '0;
        slew_cnt <= '0;
        slewing  <= 1'b0;
      end else begin
        if (ena) begin
          phase <= nco_sum[NCO_BITS-1:0];
        end
        slew_cnt <= slew_nxt;
        slewing  <= (slew_nxt != '0);
        if (adv) begin
          half      <= ~half;
          half_chip <= 1'b1;
          if (half) begin
            full_chip <= 1'b1;
            if (nchip == LAST_CHIP) begin
              nchip <= '0;
              epoch <= 1'b1;
            end else begin
              nchip <= nchip + CHIP_ONE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_e1b_chip_nco.sv
// Scoreboard bench for e1b_chip_nco: stimulus pushes expected half-chip
// events, a negedge monitor pops and compares them as the DUT emits pulses.
module tb_e1b_chip_nco;

  localparam int CODELEN = 4092;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        init = 1'b0;
  logic        rate_wr = 1'b0;
  logic [31:0] rate = '0;
  logic        slew_wr = 1'b0;
  logic [15:0] slew = '0;
  logic [11:0] nchip;
  logic        full_chip;
  logic        half_chip;
  logic        epoch;
  logic        slewing;

  e1b_chip_nco #(.E1B_CODEBITS(12), .E1B_CODELEN(4092), .NCO_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .init(init),
    .rate_wr(rate_wr), .rate(rate), .slew_wr(slew_wr), .slew(slew),
    .nchip(nchip), .full_chip(full_chip), .half_chip(half_chip),
    .epoch(epoch), .slewing(slewing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   nchip;
    logic full;
    logic epoch;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  e_half = 0;
  int  slew_left = 0;
  bit  par = 1'b0;
  bit  model_on = 1'b0;
  int  last_cyc = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int at_cyc, input int nc, input logic fu, input logic ep);
    ev_t r;
    r.cyc = at_cyc; r.nchip = nc; r.full = fu; r.epoch = ep;
    sb.push_back(r);
  endtask

  // Reference at rate 2^31: every second ena carries; each unswallowed tick is one half-chip.
  task automatic step(input bit e, input bit in_init = 1'b0, input bit sw = 1'b0,
                      input int unsigned sv = 0, input bit rw = 1'b0,
                      input logic [31:0] rv = 32'h0);
    int nc;
    bit fu;
    @(negedge clk);
    ena = e; init = in_init; slew_wr = sw; slew = sv[15:0]; rate_wr = rw; rate = rv;
    last_cyc = cyc;
    if (in_init) begin
      e_half = 0; slew_left = 0; par = 1'b0;
    end else if (model_on) begin
      if (sw) slew_left = int'(sv);
      if (e) begin
        par = ~par;
        if (!par) begin
          if (slew_left > 0) begin
            slew_left--;
          end else begin
            e_half++;
            fu = (e_half % 2 == 0);
            nc = (e_half / 2) % CODELEN;
            push_ev(last_cyc + 1, nc, fu, fu && (nc == 0));
          end
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1);
  endtask

  function automatic int outs();
    return int'({nchip, full_chip, half_chip, epoch, slewing});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (half_chip) begin
        if (sb.size() == 0) begin
          chk("unexpected_half_chip", 1, 0);
        end else begin
          ev_t r;
          r = sb.pop_front();
          chk("event_cycle", cyc, r.cyc);
          chk("event_nchip", int'(nchip), r.nchip);
          chk("event_flags", int'({full_chip, epoch, slewing}), int'({r.full, r.epoch, 1'b0}));
        end
      end else if (full_chip || epoch) begin
        chk("pulse_without_half_chip", int'({full_chip, epoch}), 0);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_event_at_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cycle_after_release", outs(), 0);
    repeat (100) step(1'b0);
    chk("idle_outputs", outs(), 0);

    // Basic rate 2^31, then slew of 3 half-chips at nchip 100
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h8000_0000);
    model_on = 1'b1;
    run(400);
    chk("nchip_before_slew", int'(nchip), 99);
    step(1'b1, 1'b0, 1'b1, 3);
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
      chk("slewing_during_slew", int'(slewing), (k < 5) ? 1 : 0);
    end

    // Cancel a slew in progress with slew=0
    step(1'b1);
    step(1'b1, 1'b0, 1'b1, 5);
    step(1'b1);
    chk("slewing_cancel_pre", int'(slewing), 1);
    step(1'b1, 1'b0, 1'b1, 0);
    chk("slewing_cancel_mid", int'(slewing), 1);
    step(1'b1);
    chk("slewing_cancel_drop", int'(slewing), 0);

    // Run through the 4091 -> 0 wrap
    run(16400);

    // init together with slew_wr
    step(1'b1, 1'b0, 1'b1, 7);
    step(1'b1);
    chk("slewing_before_init", int'(slewing), 1);
    step(1'b1, 1'b1, 1'b1, 9);
    step(1'b0);
    chk("init_nchip", int'(nchip), 0);
    chk("init_slewing", int'(slewing), 0);
    run(4);

    // rate_wr with ena: that ena still uses 2^31, later ones 2^30
    model_on = 1'b0;
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h4000_0000);
    step(1'b1);
    step(1'b1);
    push_ev(last_cyc + 1, 1, 1'b0, 1'b0);
    repeat (4) step(1'b1);
    push_ev(last_cyc + 1, 2, 1'b1, 1'b0);
    repeat (3) step(1'b0);
    chk("rate_test_drained", sb.size(), 0);

    // Async reset mid-slew at nchip 2000
    model_on = 1'b1;
    step(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h8000_0000);
    run(8000);
    step(1'b1, 1'b0, 1'b1, 10);
    repeat (3) step(1'b1);
    chk("slewing_before_async_reset", int'(slewing), 1);
    chk("nchip_before_async_reset", int'(nchip), 2000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ena = 1'b0; slew_wr = 1'b0; rate_wr = 1'b0; init = 1'b0;
    sb.delete();
    model_on = 1'b0;
    #1;
    chk("async_reset_clear", outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(20);
    chk("post_reset_rate_zero", outs(), 0);
    e_half = 0; par = 1'b0; slew_left = 0;
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h8000_0000);
    model_on = 1'b1;
    run(8);
    repeat (3) step(1'b0);
    chk("final_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/e1b_chip_nco.md
Name: e1b_chip_nco

Overview:
- Per-channel E1B code-phase generator, one instance per GPS channel.
- Sits directly upstream of the E1B code memory: produces that stage's nchip_n slice and full_chip strobe for its channel.
- A 32-bit code NCO advances a half-chip/full-chip counter that wraps at the E1B code length and flags code epochs.
- Supports host rate loading, code-phase slew (half-chip hold) and synchronous restart.

Parameters:
- E1B_CODEBITS, 12, width of chip index.
- E1B_CODELEN, 4092, chips per primary code period; index range 0..E1B_CODELEN-1.
- NCO_BITS, 32, width of code NCO phase accumulator and rate word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  sample strobe; NCO advances only when high.
- init  in  1  synchronous restart of phase/chip state.
- rate_wr  in  1  load strobe for rate.
- rate  in  NCO_BITS  code NCO increment per ena, in half-chips × 2^NCO_BITS.
- slew_wr  in  1  load strobe for slew.
- slew  in  16  number of half-chip ticks to swallow.
- nchip  out  E1B_CODEBITS  current chip index.
- full_chip  out  1  one-cycle pulse at each chip boundary.
- half_chip  out  1  one-cycle pulse at each half-chip tick that advances the code.
- epoch  out  1  one-cycle pulse coincident with full_chip when nchip wraps to 0.
- slewing  out  1  high while slew_cnt != 0.

Behaviour:
- Reset (rst_n low, asynchronous): clear phase, rate_q, slew_cnt, nchip, half (parity bit), full_chip, half_chip, epoch, slewing.
  - All outputs are 0 during reset and in the first cycle after release.
- Rate loading:
  - rate_wr registers rate into rate_q.
  - The new rate is used from the next ena cycle on; a same-cycle ena uses the old rate_q.
- NCO: on ena, {carry, phase} <= phase + rate_q (NCO_BITS+1-bit add); carry generates a tick.
  - At most one tick per ena.
  - No ena means no state change other than register loads.
- Tick handling, priority order:
  - init: phase<=0, half<=0, nchip<=0, slew_cnt<=0. No pulses that cycle. rate_q is kept.
  - slew_cnt != 0 (after any same-cycle slew_wr load): the tick decrements slew_cnt. nchip and half are unchanged, no pulses.
  - Otherwise: half<=~half and half_chip pulses.
    - If half was 1: full_chip pulses and nchip advances.
    - nchip advances to nchip+1, or to 0 when nchip==E1B_CODELEN-1; in the wrap case epoch pulses too.
- Pulse/index alignment:
  - Pulses are registered and high for exactly one cycle, the cycle after the tick cycle.
  - nchip updates on the same edge that raises full_chip, so the new index is visible during the full_chip cycle.
  - The code memory pre-fetches nchip+1 and latches it on full_chip.
- Slew:
  - slew_wr loads slew_cnt<=slew. If a tick occurs in the same cycle, it is applied against the newly loaded value, so the result is slew-1 when slew != 0.
  - slew=0 cancels any slew in progress.
  - slewing = (slew_cnt != 0), registered.
- init and slew_wr in the same cycle: init wins and slew_cnt ends at 0.
- Rate precondition: consecutive full_chip pulses must be ≥ GPS_CHANS+2 clk cycles apart (round-robin service of the code memory).
  - Software guarantees this through rate and ena spacing; the block does not check it.
- Arithmetic: the NCO add wraps modulo 2^NCO_BITS. nchip never takes values ≥ E1B_CODELEN.

Test Plan:
- Reset/idle: hold rst_n=0, then release with ena=0 for 100 cycles → all outputs 0, nchip=0.
- Basic rate: rate=2^31, ena every cycle.
  - half_chip every 2 cycles; full_chip every 4 cycles.
  - nchip counts 1,2,3…; epoch once per 16368 cycles, coincident with nchip returning to 0 from 4091.
- Slew: mid-run at nchip=100, slew_wr with slew=3 → next 3 ticks swallowed and slewing high for them.
  - The following full_chip is delayed by 3 half-chip periods (6 cycles at rate 2^31).
  - slew=0 written mid-slew → slewing drops next cycle and advance resumes.
- Simultaneous events:
  - init+slew_wr together → slew_cnt=0, nchip=0, phase=0.
  - rate_wr with ena → that ena uses the old rate; verify by phase readback via tick timing.
- Wrap boundary: run nchip to 4091 → next full_chip gives nchip=0 with epoch=1 that cycle; never 4092.
- Async reset mid-run: drop rst_n between clk edges at nchip=2000 mid-slew → outputs clear immediately with no clock; after release, counting restarts from 0 using rate_q=0 until rate_wr.
